shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier built around a ripple-carry adder.
//   Uses one shift-add iteration per clock. Its datapath adder is a WIDTH-bit chain of full_adder cells.
//   Consumes the adder's sum/carry each cycle and presents a registered product to downstream logic.
// PARAMETERS
//   WIDTH  4  operand width in bits; product is 2*WIDTH; legal range 2..16
// PORTS
//   clk      in   1        single clock, rising edge
//   rst_n    in   1        asynchronous, active-low reset
//   start    in   1        request; sampled only in IDLE
//   a        in   WIDTH    multiplicand, captured on accepted start
//   b        in   WIDTH    multiplier, captured on accepted start
//   busy     out  1        high in RUN and DONE states
//   done     out  1        one-cycle pulse: product valid
//   product  out  2*WIDTH  a*b; held stable until next accepted start
// BEHAVIOUR
//   Reset (async assert, sync deassert by clk): state=IDLE, busy=0, done=0, product=0, internal regs=0.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE, start=1:
//     mcand<=a, mplier<=b, acc<=0, cnt<=0, go to RUN.
//     product keeps its old value until DONE.
//   RUN, each cycle:
//     {cout,sum} = acc + (mplier[0] ? mcand : 0)   (WIDTH-bit ripple add, carry-in 0).
//     {acc,mplier} <= {cout,sum,mplier} >> 1   (carry enters acc MSB).
//     cnt<=cnt+1.
//     After WIDTH iterations go to DONE.
//   DONE, single cycle:
//     product<={acc,mplier}, done=1, go to IDLE.
//     busy stays 1 in this cycle, drops to 0 the next.
//   Latency: start accepted at edge k -> done high in the cycle following edge k+WIDTH+1.
//     Example: WIDTH=4 -> done asserted WIDTH+1=5 cycles after the start edge.
//   start while busy (RUN or DONE) is ignored; no queueing.
//     Operands must be re-presented after done.
//   Back-to-back: start may be high in the cycle after done.
//     That is, it is accepted in IDLE, giving a throughput of one result per WIDTH+2 cycles.
//   Width: product is exactly 2*WIDTH bits, so no overflow is possible.
//     The max case (2^W-1)^2 fits.
//   Reset mid-operation aborts immediately. All outputs return to reset values and no done is issued.
//   a/b may change freely after the start cycle; only the captured copies are used.
//   cnt must be sized to hold WIDTH; no wrap-around within one operation.
// CONFIGURATION
//   EARLY_EXIT_EN defined:
//     RUN exits as soon as the unconsumed multiplier bits are all zero.
//     At least 1 RUN iteration is always executed.
//     Iterations = max(1, msb_index(b)+1).
//     product = {acc,mplier} >> (WIDTH - iterations) so the result is still a*b.
//     done arrives iterations+1 cycles after the start edge.
//   EARLY_EXIT_EN undefined:
//     Fixed WIDTH iterations and fixed latency as above.
//     No early-exit or barrel-shift logic is synthesised.
// TESTING
//   WIDTH=4, a=3, b=3, start 1 cycle -> done pulse 5 cycles later, product=8'd9, busy low next cycle.
//   a=15, b=15 -> product=8'd225 (0xE1), checks carry into acc MSB.
//     With EARLY_EXIT_EN same latency (b MSB set).
//   a=7, b=0 -> product=0.
//     Without macro: done at +5.
//     With EARLY_EXIT_EN: done at +2.
//   Start a=5,b=6, then at +2 start with a=9,b=9 ->
//     second start ignored, product=30, no second done.
//   Start a=12,b=11, assert rst_n=0 at +3 ->
//     busy=0, done=0, product=0 immediately, no done after release.
//   Exhaustive back-to-back: all 256 (a,b) pairs, each started the cycle after done ->
//     every product equals a*b; exactly one done per operation.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier. Each clock does one
//   shift-add step through a WIDTH-bit ripple-carry chain of full-adder cells.
//   The result is registered and held until the next accepted start.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request, sampled only when idle
//   a        in   WIDTH    multiplicand, captured on accepted start
//   b        in   WIDTH    multiplier, captured on accepted start
//   busy     out  1        high while an operation is in progress (RUN/DONE)
//   done     out  1        one-cycle pulse, product valid
//   product  out  2*WIDTH  a*b, held until the next result
//
// Build option
//   EARLY_EXIT_EN : stop iterating once the unconsumed multiplier bits are zero
//                   (at least one iteration) and realign the result with a shift.

module shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic               last_iter;

`ifdef EARLY_EXIT_EN
  // Copy of the multiplier bits not yet consumed; zero means the rest of the
  // iterations would only shift.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      shamt;
  assign shamt = CW'(WIDTH) - cnt_q;
`endif

  // Ripple-carry adder: acc + (mplier[0] ? mcand : 0), carry-in 0.
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = acc_q[i] ^ addend[i] ^ carry[i];
    assign carry[i+1] = (acc_q[i] & addend[i]) | (carry[i] & (acc_q[i] ^ addend[i]));
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    last_iter = 1'b0;
`ifdef EARLY_EXIT_EN
    rem_d     = rem_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef EARLY_EXIT_EN
          rem_d    = b;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // {acc,mplier} <= {cout,sum,mplier} >> 1
        acc_d    = {carry[WIDTH], sum[WIDTH-1:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
`ifdef EARLY_EXIT_EN
        rem_d     = rem_q >> 1;
        last_iter = (cnt_d == CW'(WIDTH)) || ((rem_q >> 1) == '0);
`else
        last_iter = (cnt_d == CW'(WIDTH));
`endif
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef EARLY_EXIT_EN
        // Stopping after cnt steps leaves a*b shifted left by WIDTH-cnt.
        product_d = {acc_q, mplier_q} >> shamt;
`else
        product_d = {acc_q, mplier_q};
`endif
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifdef EARLY_EXIT_EN
      rem_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
`ifdef EARLY_EXIT_EN
      rem_q     <= rem_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier (WIDTH=4). A timeline model predicts
// busy/done/product every cycle; directed vectors add literal expectations.

module tb_shift_add_multiplier;

  localparam int unsigned W = 4;

`ifdef EARLY_EXIT_EN
  localparam int LAT_33 = 3;
  localparam int LAT_70 = 2;
`else
  localparam int LAT_33 = 5;
  localparam int LAT_70 = 5;
`endif
  localparam int LAT_FF = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int tests = 0;
  int fails = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // Cycles from the accepting edge until done is visible.
  function automatic int exp_latency(input logic [W-1:0] bb);
    int it;
    it = 1;
    for (int i = 0; i < W; i++) begin
      if (bb[i]) it = i + 1;
    end
`ifndef EARLY_EXIT_EN
    it = W;
`endif
    return it + 1;
  endfunction

  // Timeline model: an accepted start at edge s finishes at edge s+lat;
  // busy covers edges s..s+lat-1, done and the new product appear at s+lat.
  int             edge_n    = 0;
  bit             m_active  = 1'b0;
  bit             m_busy    = 1'b0;
  bit             m_done    = 1'b0;
  bit             prev_busy = 1'b0;
  int             m_start   = 0;
  int             m_lat     = 0;
  logic [2*W-1:0] m_pend    = '0;
  logic [2*W-1:0] m_product = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active  = 1'b0;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_product = '0;
    end else begin
      prev_busy = m_busy;
      edge_n++;
      m_done = 1'b0;
      if (m_active && edge_n == m_start + m_lat) begin
        m_product = m_pend;
        m_done    = 1'b1;
        m_active  = 1'b0;
      end else if (start && !prev_busy) begin
        m_active = 1'b1;
        m_start  = edge_n;
        m_lat    = exp_latency(b);
        m_pend   = (2*W)'(a) * (2*W)'(b);
      end
      m_busy = m_active;
    end
  end

  int dut_dones = 0;

  always @(negedge clk) begin
    check("cyc busy", 32'(busy), 32'(m_busy));
    check("cyc done", 32'(done), 32'(m_done));
    check("cyc product", 32'(product), 32'(m_product));
    if (done === 1'b1) dut_dones++;
  end

  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic [2*W-1:0] exp_p, input int exp_lat, input string name);
    int n;
    n = 0;
    @(posedge clk); #1;
    start = 1'b1; a = op_a; b = op_b;
    @(posedge clk); #1;
    start = 1'b0; a = ~op_a; b = ~op_b;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " product"}, 32'(product), 32'(exp_p));
    @(posedge clk); #1;
    check({name, " busy after"}, 32'(busy), 32'd0);
    check({name, " done after"}, 32'(done), 32'd0);
    check({name, " product held"}, 32'(product), 32'(exp_p));
  endtask

  int n;
  int base;
  int pa;
  int pb;
  int total;

  initial begin
    start = 1'b0;
    a     = '0;
    b     = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(4'd3, 4'd3, 8'd9, LAT_33, "3x3");
    check("model 3x3", 32'(m_product), 32'd9);
    run_op(4'd15, 4'd15, 8'hE1, LAT_FF, "15x15");
    check("model 15x15", 32'(m_product), 32'd225);
    run_op(4'd7, 4'd0, 8'd0, LAT_70, "7x0");
    run_op(4'd1, 4'd8, 8'd8, LAT_FF, "1x8");

    // Start while busy must be ignored.
    base = dut_dones;
    @(posedge clk); #1;
    start = 1'b1; a = 4'd5; b = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 4'd9; b = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    check("ignore done seen", 32'(n != 0), 32'd1);
    check("ignore product", 32'(product), 32'd30);
    repeat (12) @(posedge clk);
    #1;
    check("ignore one done", 32'(dut_dones - base), 32'd1);
    check("ignore product held", 32'(product), 32'd30);

    // Reset mid-operation aborts.
    base = dut_dones;
    @(posedge clk); #1;
    start = 1'b1; a = 4'd12; b = 4'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort no done", 32'(dut_dones - base), 32'd0);
    check("abort product after", 32'(product), 32'd0);
    check("abort busy after", 32'(busy), 32'd0);

    // Exhaustive back-to-back: next start presented in the done cycle.
    total = 1 << (2 * W);
    base  = dut_dones;
    @(posedge clk); #1;
    start = 1'b1; a = '0; b = '0;
    for (int p = 0; p < total; p++) begin
      pa = p >> W;
      pb = p & ((1 << W) - 1);
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (done === 1'b1) begin
          n = i;
          break;
        end
      end
      check("b2b latency", 32'(n), 32'(exp_latency(W'(pb))));
      check("b2b product", 32'(product), 32'(pa * pb));
      if (p + 1 < total) begin
        start = 1'b1;
        a = W'((p + 1) >> W);
        b = W'((p + 1) & ((1 << W) - 1));
      end
    end
    repeat (10) @(posedge clk);
    #1;
    check("b2b done count", 32'(dut_dones - base), 32'(total));
    check("b2b final product", 32'(product), 32'd225);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
